multicycle_ctrl: RTL and testbench

- Main control FSM for the multi-cycle RV32I core; sequences the shared ALU, memory port, IR, PC and register file over several cycles per instruction.
- Drives the 2-bit ALU-op code consumed by the ALU-control decoder; func3/func7 are routed from the IR straight to that decoder, not through this block.
- Supports R-type, I-type ALU, lw, sw and beq, waits on a memory-ready handshake, flags illegal opcodes and counts retired instructions.

---
 rtl/multicycle_pkg.sv | 59 +++++
 rtl/multicycle_outdec.sv | 69 ++++++
 rtl/multicycle_ctrl.sv | 109 ++++++++++
 tb/tb_multicycle_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM states, opcodes,
// ALU-op codes, datapath mux selects and the control word bundle.
package multicycle_pkg;

  localparam int unsigned STATE_W  = 4;
  localparam int unsigned OPCODE_W = 7;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_R   = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_I   = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_LW  = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_SW  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic       ADR_PC     = 1'b0;
  localparam logic       ADR_ALUOUT = 1'b1;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEMDATA = 2'b01;
  localparam logic [1:0] RES_ALURES  = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       adr_src;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] aluop;
    logic       imm_alu;
  } ctrl_t;

endpackage

// File: rtl/multicycle_outdec.sv
// Combinational decode of the current FSM state into the datapath control word.
module multicycle_outdec
  import multicycle_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  input  logic   zero,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.adr_src    = ADR_PC;
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.aluop      = ALUOP_ADD;
        ctrl.result_src = RES_ALURES;
        // IR and PC only latch once the instruction word has arrived
        ctrl.ir_write   = mem_ready;
        ctrl.pc_write   = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.aluop     = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.aluop     = ALUOP_ADD;
      end
      S_MEMREAD: ctrl.adr_src = ADR_ALUOUT;
      S_MEMWB: begin
        ctrl.result_src = RES_MEMDATA;
        ctrl.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.adr_src   = ADR_ALUOUT;
        ctrl.mem_write = 1'b1;
      end
      S_EXECR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_RS2;
        ctrl.aluop     = ALUOP_FUNC;
      end
      S_EXECI: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.aluop     = ALUOP_FUNC;
        ctrl.imm_alu   = 1'b1;
      end
      S_ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_write  = 1'b1;
      end
      S_BEQ: begin
        ctrl.alu_src_a  = SRCA_RS1;
        ctrl.alu_src_b  = SRCB_RS2;
        ctrl.aluop      = ALUOP_SUB;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_write   = zero;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core: sequences fetch, decode and
// execute, flags unsupported opcodes and counts retired instructions.
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [3:0]       state,
  output logic             pc_write,
  output logic             ir_write,
  output logic             adr_src,
  output logic             mem_write,
  output logic             reg_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       aluop,
  output logic             imm_alu,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             illegal_q, illegal_d;
  logic             retire;
  ctrl_t            ctrl;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
  end

  // Next state, retire strobe and illegal-opcode flag
  always_comb begin
    state_d   = state_q;
    illegal_d = 1'b0;
    retire    = 1'b0;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR:   state_d = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_MEMWRITE: begin
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXECR, S_EXECI: state_d = S_ALUWB;
      S_ALUWB, S_BEQ: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
    retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
  end

  multicycle_outdec u_outdec (
    .state     (state_q),
    .mem_ready (mem_ready),
    .zero      (zero),
    .ctrl      (ctrl)
  );

  // Write enables are suppressed for the whole reset cycle
  assign pc_write   = ctrl.pc_write  & ~reset;
  assign ir_write   = ctrl.ir_write  & ~reset;
  assign mem_write  = ctrl.mem_write & ~reset;
  assign reg_write  = ctrl.reg_write & ~reset;
  assign adr_src    = ctrl.adr_src;
  assign result_src = ctrl.result_src;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign aluop      = ctrl.aluop;
  assign imm_alu    = ctrl.imm_alu;
  assign state      = state_q;
  assign illegal    = illegal_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: instruction-level model plans each
// cycle's expected outputs; a monitor compares them at the falling edge.
module tb_multicycle_ctrl;

  localparam int unsigned CW = 4;

  localparam logic [3:0] S_FE = 4'd0, S_DE = 4'd1, S_MA = 4'd2, S_MR = 4'd3,
                         S_MB = 4'd4, S_MW = 4'd5, S_XR = 4'd6, S_XI = 4'd7,
                         S_AW = 4'd8, S_BQ = 4'd9;

  localparam logic [6:0] O_R = 7'b0110011, O_I = 7'b0010011, O_LW = 7'b0000011,
                         O_SW = 7'b0100011, O_BEQ = 7'b1100011;

  logic          clk = 1'b0;
  logic          reset, zero, mem_ready;
  logic [6:0]    opcode;
  logic [3:0]    state;
  logic          pc_write, ir_write, adr_src, mem_write, reg_write, imm_alu, illegal;
  logic [1:0]    result_src, alu_src_a, alu_src_b, aluop;
  logic [CW-1:0] retired;

  always #5 clk = ~clk;

  multicycle_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .state(state), .pc_write(pc_write), .ir_write(ir_write), .adr_src(adr_src),
    .mem_write(mem_write), .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .aluop(aluop),
    .imm_alu(imm_alu), .illegal(illegal), .retired(retired)
  );

  typedef struct packed {
    logic [3:0]    state;
    logic          pc_write, ir_write, adr_src, mem_write, reg_write;
    logic [1:0]    result_src, alu_src_a, alu_src_b, aluop;
    logic          imm_alu, illegal;
    logic [CW-1:0] retired;
  } obs_t;

  obs_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned m_retired = 0;
  logic        m_illegal = 1'b0;

  function automatic bit is_legal(input logic [6:0] op);
    return op == O_R || op == O_I || op == O_LW || op == O_SW || op == O_BEQ;
  endfunction

  // Expected control word for one cycle, straight from the state table
  function automatic obs_t expect_for(input logic [3:0] st, input logic mr,
                                      input logic z, input logic rst);
    obs_t e;
    e = '0;
    e.state   = st;
    e.illegal = m_illegal;
    e.retired = CW'(m_retired);
    case (st)
      S_FE: begin e.alu_src_b = 2'b10; e.result_src = 2'b10; e.ir_write = mr; e.pc_write = mr; end
      S_DE: begin e.alu_src_a = 2'b01; e.alu_src_b = 2'b01; end
      S_MA: begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; end
      S_MR: e.adr_src = 1'b1;
      S_MB: begin e.result_src = 2'b01; e.reg_write = 1'b1; end
      S_MW: begin e.adr_src = 1'b1; e.mem_write = 1'b1; end
      S_XR: begin e.alu_src_a = 2'b10; e.aluop = 2'b10; end
      S_XI: begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; e.aluop = 2'b10; e.imm_alu = 1'b1; end
      S_AW: e.reg_write = 1'b1;
      S_BQ: begin e.alu_src_a = 2'b10; e.aluop = 2'b01; e.pc_write = z; end
      default: ;
    endcase
    if (rst) begin
      e.pc_write = 1'b0; e.ir_write = 1'b0; e.mem_write = 1'b0; e.reg_write = 1'b0;
    end
    return e;
  endfunction

  // Drive one cycle of inputs, queue its expectation, then advance the model
  task automatic cyc(input logic [3:0] st, input logic mr, input logic rst,
                     input logic [6:0] op, input logic z, input bit ret, input bit ill);
    reset = rst; mem_ready = mr; opcode = op; zero = z;
    exp_q.push_back(expect_for(st, mr, z, rst));
    @(posedge clk); #1;
    if (rst) begin
      m_retired = 0;
      m_illegal = 1'b0;
    end else begin
      m_illegal = ill;
      if (ret) m_retired = (m_retired + 1) % (1 << CW);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input logic z);
    for (int i = 0; i < fw; i++) cyc(S_FE, 1'b0, 1'b0, 7'($urandom), rb(), 0, 0);
    cyc(S_FE, 1'b1, 1'b0, 7'($urandom), rb(), 0, 0);
    cyc(S_DE, rb(), 1'b0, op, rb(), 0, !is_legal(op));
    case (op)
      O_R: begin
        cyc(S_XR, rb(), 1'b0, op, rb(), 0, 0);
        cyc(S_AW, rb(), 1'b0, op, rb(), 1, 0);
      end
      O_I: begin
        cyc(S_XI, rb(), 1'b0, op, rb(), 0, 0);
        cyc(S_AW, rb(), 1'b0, op, rb(), 1, 0);
      end
      O_BEQ: cyc(S_BQ, rb(), 1'b0, op, z, 1, 0);
      O_LW: begin
        cyc(S_MA, rb(), 1'b0, op, rb(), 0, 0);
        for (int i = 0; i < mw; i++) cyc(S_MR, 1'b0, 1'b0, op, rb(), 0, 0);
        cyc(S_MR, 1'b1, 1'b0, op, rb(), 0, 0);
        cyc(S_MB, rb(), 1'b0, op, rb(), 1, 0);
      end
      O_SW: begin
        cyc(S_MA, rb(), 1'b0, op, rb(), 0, 0);
        for (int i = 0; i < mw; i++) cyc(S_MW, 1'b0, 1'b0, op, rb(), 0, 0);
        cyc(S_MW, 1'b1, 1'b0, op, rb(), 1, 0);
      end
      default: ;
    endcase
  endtask

  // Monitor: pop and compare one expectation per cycle, mid-cycle
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        obs_t e, a;
        e = exp_q.pop_front();
        a = '{state, pc_write, ir_write, adr_src, mem_write, reg_write, result_src,
              alu_src_a, alu_src_b, aluop, imm_alu, illegal, retired};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL ctrl_word t=%0t state got=%0d exp=%0d retired got=%0d exp=%0d word got=%h exp=%h",
                   $time, a.state, e.state, a.retired, e.retired, a, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    logic [6:0] op;
    int k;
    reset = 1'b1; mem_ready = 1'b1; opcode = '0; zero = 1'b0;
    @(posedge clk); #1;
    cyc(S_FE, 1'b1, 1'b1, 7'd0, 1'b0, 0, 0);

    run_instr(O_R, 0, 0, 1'b0);
    run_instr(O_LW, 0, 2, 1'b0);
    run_instr(O_BEQ, 0, 0, 1'b1);
    run_instr(O_BEQ, 0, 0, 1'b0);
    run_instr(7'b1111111, 0, 0, 1'b0);
    run_instr(O_I, 1, 0, 1'b0);
    run_instr(O_SW, 0, 1, 1'b0);

    // Reset while a store is stalled on the memory port
    cyc(S_FE, 1'b1, 1'b0, 7'd0, 1'b0, 0, 0);
    cyc(S_DE, 1'b1, 1'b0, O_SW, 1'b0, 0, 0);
    cyc(S_MA, 1'b1, 1'b0, O_SW, 1'b0, 0, 0);
    cyc(S_MW, 1'b0, 1'b0, O_SW, 1'b0, 0, 0);
    cyc(S_MW, 1'b0, 1'b1, O_SW, 1'b0, 0, 0);

    for (int n = 0; n < 150; n++) begin
      k = int'($urandom_range(5, 0));
      case (k)
        0: op = O_R;
        1: op = O_I;
        2: op = O_LW;
        3: op = O_SW;
        4: op = O_BEQ;
        default: begin
          op = 7'($urandom);
          while (is_legal(op)) op = 7'($urandom);
        end
      endcase
      run_instr(op, int'($urandom_range(2, 0)), int'($urandom_range(3, 0)), rb());
    end
    cyc(S_FE, 1'b0, 1'b0, 7'd0, 1'b0, 0, 0);

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
